// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit: main FSM plus ALU decoder, with a memory
// ready/request handshake, wait timeout, bne/jal support and illegal-instruction flag.
module mc_control_fsm #(
    parameter int ALUCTRL_W = 3,
    parameter int MAX_WAIT  = 8,
    parameter bit HAS_JAL   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           Opcode,
    input  logic [5:0]           Funct,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 IorD,
    output logic                 ALUSrcA,
    output logic                 IRWrite,
    output logic                 MemWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic                 Branch,
    output logic                 BranchNE,
    output logic                 ImmZext,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           PCSrc,
    output logic [1:0]           MemtoReg,
    output logic [1:0]           RegDst,
    output logic [3:0]           state,
    output logic                 instr_done,
    output logic                 illegal_instr,
    output logic                 mem_err
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
        S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP  = 4'd11,
        S_JAL    = 4'd12, S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000, OP_LW   = 6'b100011, OP_SW  = 6'b101011,
                           OP_BEQ  = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000,
                           OP_ANDI = 6'b001100, OP_ORI  = 6'b001101, OP_J    = 6'b000010,
                           OP_JAL  = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100,
                           FN_OR  = 6'b100101, FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                           ALU_OR  = 3'b001, ALU_SLT = 3'b111;

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_hit;
    logic             err_set;
    logic             is_store;
    logic [2:0]       alu_op;

    // The counter holds completed wait cycles, so the cycle that would make it
    // MAX_WAIT is itself the timeout cycle.
    assign wait_hit = (MAX_WAIT != 0) && (wait_cnt == WAIT_LAST);
    assign state    = state_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
            is_store <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || mem_ready || !mem_req)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;
            if (err_set)
                mem_err <= 1'b1;
            if (state_q == S_DECODE)
                is_store <= (Opcode == OP_SW);
        end
    end

    // NOTE: every output is given a default before the case so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        err_set       = 1'b0;
        alu_op        = 3'b000;
        mem_req       = 1'b0;
        IorD          = 1'b0;
        ALUSrcA       = 1'b0;
        IRWrite       = 1'b0;
        MemWrite      = 1'b0;
        PCWrite       = 1'b0;
        RegWrite      = 1'b0;
        Branch        = 1'b0;
        BranchNE      = 1'b0;
        ImmZext       = 1'b0;
        ALUSrcB       = 2'b00;
        PCSrc         = 2'b00;
        MemtoReg      = 2'b00;
        RegDst        = 2'b00;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = 2'b01;
                alu_op  = ALU_ADD;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = S_DECODE;
                else if (wait_hit) begin
                    state_d = S_HALT;
                    err_set = 1'b1;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                alu_op  = ALU_ADD;
                case (Opcode)
                    OP_LW, OP_SW:             state_d = S_MEMADR;
                    OP_R:                     state_d = S_EXEC;
                    OP_BEQ, OP_BNE:           state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
                    OP_J:                     state_d = S_JUMP;
                    OP_JAL: begin
                        if (HAS_JAL) state_d = S_JAL;
                        else begin
                            illegal_instr = 1'b1;
                            state_d       = S_FETCH;
                        end
                    end
                    default: begin
                        illegal_instr = 1'b1;
                        state_d       = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu_op  = ALU_ADD;
                state_d = is_store ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
                else if (wait_hit) begin
                    state_d = S_HALT;
                    err_set = 1'b1;
                end
            end
            S_MEMWB: begin
                MemtoReg   = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                IorD       = 1'b1;
                MemWrite   = mem_ready || !wait_hit;
                instr_done = mem_ready;
                if (mem_ready) state_d = S_FETCH;
                else if (wait_hit) begin
                    state_d = S_HALT;
                    err_set = 1'b1;
                end
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                state_d = S_ALUWB;
                case (Funct)
                    FN_ADD: alu_op = ALU_ADD;
                    FN_SUB: alu_op = ALU_SUB;
                    FN_AND: alu_op = ALU_AND;
                    FN_OR:  alu_op = ALU_OR;
                    FN_SLT: alu_op = ALU_SLT;
                    default: begin
                        illegal_instr = 1'b1;
                        state_d       = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                RegDst     = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                alu_op     = ALU_SUB;
                PCSrc      = 2'b01;
                Branch     = (Opcode == OP_BEQ);
                BranchNE   = (Opcode == OP_BNE);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_IWB;
                case (Opcode)
                    OP_ANDI: begin alu_op = ALU_AND; ImmZext = 1'b1; end
                    OP_ORI:  begin alu_op = ALU_OR;  ImmZext = 1'b1; end
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_IWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                PCSrc      = 2'b10;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                PCSrc      = 2'b10;
                PCWrite    = 1'b1;
                RegWrite   = 1'b1;
                RegDst     = 2'b10;
                MemtoReg   = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        ALUControl      = '0;
        ALUControl[2:0] = alu_op;

        // Reset is asynchronous, so outputs are killed combinationally the
        // moment rst falls rather than waiting for the register to update.
        if (!rst) begin
            mem_req       = 1'b0;
            IorD          = 1'b0;
            ALUSrcA       = 1'b0;
            IRWrite       = 1'b0;
            MemWrite      = 1'b0;
            PCWrite       = 1'b0;
            RegWrite      = 1'b0;
            Branch        = 1'b0;
            BranchNE      = 1'b0;
            ImmZext       = 1'b0;
            ALUControl    = '0;
            ALUSrcB       = 2'b00;
            PCSrc         = 2'b00;
            MemtoReg      = 2'b00;
            RegDst        = 2'b00;
            instr_done    = 1'b0;
            illegal_instr = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Table-driven bench for mc_control_fsm: per-cycle vectors with hand-computed
// expected state and outputs, plus hand sequences for timeout, reset and jal corners.
module tb_mc_control_fsm;

    typedef struct packed {
        logic       mem_req, iord, srca, irw, memw, pcw, regw, br, brne, zext;
        logic [2:0] alu;
        logic [1:0] srcb, pcsrc, m2r, regdst;
        logic       done, ill, err;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        logic [3:0] st;
        outs_t      o;
        string      name;
    } vec_t;

    localparam outs_t O_ZERO   = '0;
    localparam outs_t O_F1     = '{mem_req:1, irw:1, pcw:1, srcb:2'b01, alu:3'b010, default:0};
    localparam outs_t O_F0     = '{mem_req:1, srcb:2'b01, alu:3'b010, default:0};
    localparam outs_t O_DEC    = '{srcb:2'b11, alu:3'b010, default:0};
    localparam outs_t O_DECILL = '{srcb:2'b11, alu:3'b010, ill:1, default:0};
    localparam outs_t O_MA     = '{srca:1, srcb:2'b10, alu:3'b010, default:0};
    localparam outs_t O_MRD    = '{mem_req:1, iord:1, default:0};
    localparam outs_t O_MWB    = '{m2r:2'b01, regw:1, done:1, default:0};
    localparam outs_t O_MWR    = '{mem_req:1, iord:1, memw:1, done:1, default:0};
    localparam outs_t O_MWRW   = '{mem_req:1, iord:1, memw:1, default:0};
    localparam outs_t O_EXADD  = '{srca:1, alu:3'b010, default:0};
    localparam outs_t O_EXSUB  = '{srca:1, alu:3'b110, default:0};
    localparam outs_t O_EXSLT  = '{srca:1, alu:3'b111, default:0};
    localparam outs_t O_EXILL  = '{srca:1, ill:1, default:0};
    localparam outs_t O_AWB    = '{regdst:2'b01, regw:1, done:1, default:0};
    localparam outs_t O_BNE    = '{srca:1, alu:3'b110, pcsrc:2'b01, brne:1, done:1, default:0};
    localparam outs_t O_BEQ    = '{srca:1, alu:3'b110, pcsrc:2'b01, br:1, done:1, default:0};
    localparam outs_t O_IADD   = '{srca:1, srcb:2'b10, alu:3'b010, default:0};
    localparam outs_t O_IOR    = '{srca:1, srcb:2'b10, alu:3'b001, zext:1, default:0};
    localparam outs_t O_IAND   = '{srca:1, srcb:2'b10, alu:3'b000, zext:1, default:0};
    localparam outs_t O_IWB    = '{regw:1, done:1, default:0};
    localparam outs_t O_J      = '{pcsrc:2'b10, pcw:1, done:1, default:0};
    localparam outs_t O_JAL    = '{pcsrc:2'b10, pcw:1, regw:1, regdst:2'b10, m2r:2'b10, done:1, default:0};
    localparam outs_t O_HALT   = '{err:1, default:0};

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Opcode, Funct;
    logic       mem_ready;
    logic       mem_req, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, RegWrite;
    logic       Branch, BranchNE, ImmZext, instr_done, illegal_instr, mem_err;
    logic [2:0] ALUControl;
    logic [1:0] ALUSrcB, PCSrc, MemtoReg, RegDst;
    logic [3:0] state;

    logic       nj_mem_req, nj_IorD, nj_ALUSrcA, nj_IRWrite, nj_MemWrite, nj_PCWrite, nj_RegWrite;
    logic       nj_Branch, nj_BranchNE, nj_ImmZext, nj_instr_done, nj_illegal_instr, nj_mem_err;
    logic [3:0] nj_ALUControl;
    logic [1:0] nj_ALUSrcB, nj_PCSrc, nj_MemtoReg, nj_RegDst;
    logic [3:0] nj_state;

    outs_t act;
    int    passed = 0;
    int    total  = 0;
    vec_t  vecs[$];

    always #5 clk = ~clk;

    mc_control_fsm #(.ALUCTRL_W(3), .MAX_WAIT(8), .HAS_JAL(1'b1)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .IorD(IorD), .ALUSrcA(ALUSrcA), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .Branch(Branch),
        .BranchNE(BranchNE), .ImmZext(ImmZext), .ALUControl(ALUControl), .ALUSrcB(ALUSrcB),
        .PCSrc(PCSrc), .MemtoReg(MemtoReg), .RegDst(RegDst), .state(state),
        .instr_done(instr_done), .illegal_instr(illegal_instr), .mem_err(mem_err)
    );

    mc_control_fsm #(.ALUCTRL_W(4), .MAX_WAIT(8), .HAS_JAL(1'b0)) dut_nj (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .mem_ready(mem_ready),
        .mem_req(nj_mem_req), .IorD(nj_IorD), .ALUSrcA(nj_ALUSrcA), .IRWrite(nj_IRWrite),
        .MemWrite(nj_MemWrite), .PCWrite(nj_PCWrite), .RegWrite(nj_RegWrite), .Branch(nj_Branch),
        .BranchNE(nj_BranchNE), .ImmZext(nj_ImmZext), .ALUControl(nj_ALUControl),
        .ALUSrcB(nj_ALUSrcB), .PCSrc(nj_PCSrc), .MemtoReg(nj_MemtoReg), .RegDst(nj_RegDst),
        .state(nj_state), .instr_done(nj_instr_done), .illegal_instr(nj_illegal_instr),
        .mem_err(nj_mem_err)
    );

    assign act = {mem_req, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, RegWrite, Branch,
                  BranchNE, ImmZext, ALUControl, ALUSrcB, PCSrc, MemtoReg, RegDst,
                  instr_done, illegal_instr, mem_err};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h, expected %h", name, got, want);
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                       input logic [3:0] st, input outs_t o, input string name);
        vec_t v;
        v.op = op; v.fn = fn; v.rdy = rdy; v.st = st; v.o = o; v.name = name;
        vecs.push_back(v);
    endtask

    // Drive at a falling edge, compare 1 ns later, then move to the next falling edge.
    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                        input logic [3:0] st, input outs_t o, input string name);
        Opcode = op; Funct = fn; mem_ready = rdy;
        #1;
        check(name, {4'h0, state, act}, {4'h0, st, o});
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {4'h0, state, act}, {4'h0, 4'd0, O_ZERO});
        rst = 1'b1;
    endtask

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                           BNE = 6'b000101, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101,
                           J = 6'b000010, JAL = 6'b000011, BAD = 6'b111111;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_SLT = 6'b101010,
                           F_BAD = 6'b000001, F_X = 6'b000000;

    initial begin
        rst = 1'b0; Opcode = '0; Funct = '0; mem_ready = 1'b0;

        add(R, F_ADD, 1, 4'd0, O_F1, "add_fetch");   add(R, F_ADD, 1, 4'd1, O_DEC, "add_decode");
        add(R, F_ADD, 1, 4'd6, O_EXADD, "add_exec"); add(R, F_ADD, 1, 4'd7, O_AWB, "add_aluwb");
        add(R, F_SUB, 1, 4'd0, O_F1, "sub_fetch");   add(R, F_SUB, 1, 4'd1, O_DEC, "sub_decode");
        add(R, F_SUB, 1, 4'd6, O_EXSUB, "sub_exec"); add(R, F_SUB, 1, 4'd7, O_AWB, "sub_aluwb");
        add(R, F_SLT, 1, 4'd0, O_F1, "slt_fetch");   add(R, F_SLT, 1, 4'd1, O_DEC, "slt_decode");
        add(R, F_SLT, 1, 4'd6, O_EXSLT, "slt_exec"); add(R, F_SLT, 1, 4'd7, O_AWB, "slt_aluwb");
        add(LW, F_X, 1, 4'd0, O_F1, "lw_fetch");     add(LW, F_X, 0, 4'd1, O_DEC, "lw_decode");
        add(LW, F_X, 0, 4'd2, O_MA, "lw_memadr");    add(LW, F_X, 0, 4'd3, O_MRD, "lw_wait1");
        add(LW, F_X, 0, 4'd3, O_MRD, "lw_wait2");    add(LW, F_X, 0, 4'd3, O_MRD, "lw_wait3");
        add(LW, F_X, 1, 4'd3, O_MRD, "lw_memrd");    add(LW, F_X, 1, 4'd4, O_MWB, "lw_memwb");
        add(SW, F_X, 1, 4'd0, O_F1, "sw_fetch");     add(SW, F_X, 1, 4'd1, O_DEC, "sw_decode");
        add(SW, F_X, 1, 4'd2, O_MA, "sw_memadr");    add(SW, F_X, 1, 4'd5, O_MWR, "sw_memwr");
        add(BNE, F_X, 1, 4'd0, O_F1, "bne_fetch");   add(BNE, F_X, 1, 4'd1, O_DEC, "bne_decode");
        add(BNE, F_X, 1, 4'd8, O_BNE, "bne_branch");
        add(BEQ, F_X, 1, 4'd0, O_F1, "beq_fetch");   add(BEQ, F_X, 1, 4'd1, O_DEC, "beq_decode");
        add(BEQ, F_X, 1, 4'd8, O_BEQ, "beq_branch");
        add(ADDI, F_X, 1, 4'd0, O_F1, "addi_fetch"); add(ADDI, F_X, 1, 4'd1, O_DEC, "addi_decode");
        add(ADDI, F_X, 1, 4'd9, O_IADD, "addi_iexec"); add(ADDI, F_X, 1, 4'd10, O_IWB, "addi_iwb");
        add(ORI, F_X, 1, 4'd0, O_F1, "ori_fetch");   add(ORI, F_X, 1, 4'd1, O_DEC, "ori_decode");
        add(ORI, F_X, 1, 4'd9, O_IOR, "ori_iexec");  add(ORI, F_X, 1, 4'd10, O_IWB, "ori_iwb");
        add(ANDI, F_X, 1, 4'd0, O_F1, "andi_fetch"); add(ANDI, F_X, 1, 4'd1, O_DEC, "andi_decode");
        add(ANDI, F_X, 1, 4'd9, O_IAND, "andi_iexec"); add(ANDI, F_X, 1, 4'd10, O_IWB, "andi_iwb");
        add(J, F_X, 1, 4'd0, O_F1, "j_fetch");       add(J, F_X, 1, 4'd1, O_DEC, "j_decode");
        add(J, F_X, 1, 4'd11, O_J, "j_jump");
        add(BAD, F_X, 1, 4'd0, O_F1, "badop_fetch"); add(BAD, F_X, 1, 4'd1, O_DECILL, "badop_decode");
        add(R, F_BAD, 1, 4'd0, O_F1, "badfn_fetch"); add(R, F_BAD, 1, 4'd1, O_DEC, "badfn_decode");
        add(R, F_BAD, 1, 4'd6, O_EXILL, "badfn_exec");
        add(JAL, F_X, 1, 4'd0, O_F1, "jal_fetch");   add(JAL, F_X, 1, 4'd1, O_DEC, "jal_decode");
        add(JAL, F_X, 1, 4'd12, O_JAL, "jal_jal");   add(R, F_ADD, 0, 4'd0, O_F0, "after_jal_fetch");

        do_reset();
        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].op, vecs[i].fn, vecs[i].rdy, vecs[i].st, vecs[i].o, vecs[i].name);

        // mem_ready arriving on the last allowed wait cycle completes the fetch
        do_reset();
        for (int i = 0; i < 7; i++) step(R, F_ADD, 0, 4'd0, O_F0, "win_wait");
        step(R, F_ADD, 1, 4'd0, O_F1, "win_ready");
        step(R, F_ADD, 1, 4'd1, O_DEC, "win_decode");

        // fetch timeout: 8 wait cycles, then HALT with sticky error
        do_reset();
        for (int i = 0; i < 8; i++) step(R, F_ADD, 0, 4'd0, O_F0, "to_fetch_wait");
        step(R, F_ADD, 0, 4'd15, O_HALT, "to_halt");
        step(R, F_ADD, 1, 4'd15, O_HALT, "to_halt_stays");
        do_reset();
        step(R, F_ADD, 0, 4'd0, O_F0, "to_recover");

        // store timeout: MemWrite must drop on the timeout cycle
        do_reset();
        step(SW, F_X, 1, 4'd0, O_F1, "swto_fetch");
        step(SW, F_X, 1, 4'd1, O_DEC, "swto_decode");
        step(SW, F_X, 1, 4'd2, O_MA, "swto_memadr");
        for (int i = 0; i < 7; i++) step(SW, F_X, 0, 4'd5, O_MWRW, "swto_wait");
        step(SW, F_X, 0, 4'd5, O_MRD, "swto_timeout");
        step(SW, F_X, 1, 4'd15, O_HALT, "swto_halt");

        // asynchronous reset while RegWrite is high
        do_reset();
        step(ADDI, F_X, 1, 4'd0, O_F1, "ar_fetch");
        step(ADDI, F_X, 1, 4'd1, O_DEC, "ar_decode");
        step(ADDI, F_X, 1, 4'd9, O_IADD, "ar_iexec");
        #1;
        check("ar_iwb", {4'h0, state, act}, {4'h0, 4'd10, O_IWB});
        #1 rst = 1'b0;
        #1;
        check("ar_abort", {4'h0, state, act}, {4'h0, 4'd0, O_ZERO});

        // jal with HAS_JAL=0 is illegal; wide ALUControl top bit stays 0
        do_reset();
        Opcode = JAL; Funct = F_X; mem_ready = 1'b1;
        #1;
        check("nj_fetch_alu", {28'h0, nj_ALUControl}, 32'h2);
        check("nj_fetch_state", {28'h0, nj_state}, 32'h0);
        @(negedge clk); #1;
        check("nj_decode_ill", {27'h0, nj_state, nj_illegal_instr}, {27'h0, 4'd1, 1'b1});
        check("jal_decode_noill", {31'h0, illegal_instr}, 32'h0);
        @(negedge clk); #1;
        check("nj_back_fetch", {27'h0, nj_state, nj_RegWrite}, {27'h0, 4'd0, 1'b0});
        check("jal_state", {4'h0, state, act}, {4'h0, 4'd12, O_JAL});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Parametrised successor to the multicycle MIPS control unit. It combines the main FSM and the ALU decoder in one block. It adds a memory ready/request handshake with a wait timeout, bne and jal support, and an illegal-instruction flag. It sits between the instruction register and the multicycle datapath, and drives all datapath mux selects and write enables.

Parameters:
ALUCTRL_W, 3, ALUControl width; must be ≥3; bits above [2:0] are driven 0.
MAX_WAIT, 8, max consecutive cycles waiting on mem_ready before timeout; 0 disables the timeout.
HAS_JAL, 1, 1 enables jal; 0 treats opcode 000011 as illegal.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
Opcode  in  6  IR[31:26]
Funct  in  6  IR[5:0]
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, RegWrite  out  1 each  datapath enables/selects
Branch, BranchNE  out  1 each  PC write if Zero / if !Zero
ImmZext  out  1  zero-extend immediate (andi/ori)
ALUControl  out  ALUCTRL_W  010 add, 110 sub, 000 and, 001 or, 111 slt
ALUSrcB, PCSrc, MemtoReg, RegDst  out  2 each  mux selects
state  out  4  current state code (debug)
instr_done  out  1  one-cycle pulse on the final state of each instruction
illegal_instr  out  1  one-cycle pulse on an undecodable opcode or funct
mem_err  out  1  sticky timeout flag

Behaviour:
- Moore outputs are decoded from the state register. Every output not listed for a state is 0.
- While rst=0: state=FETCH (code 0), wait counter=0, mem_err=0, and all enables, mem_req and pulses are forced to 0.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, j 000010, jal 000011.
- R-type funct codes: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- State codes and actions:
  - FETCH(0): mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, add. IRWrite=PCWrite=mem_ready. Stays until mem_ready, then goes to DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, add. Next state by opcode: lw/sw→MEMADR, R→EXEC, beq/bne→BRANCH, addi/andi/ori→IEXEC, j→JUMP, jal→JAL. Any other opcode pulses illegal_instr and goes to FETCH.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, add. lw→MEMRD, sw→MEMWR.
  - MEMRD(3): mem_req=1, IorD=1. Waits for mem_ready, then goes to MEMWB.
  - MEMWB(4): RegDst=00, MemtoReg=01, RegWrite=1, instr_done. Goes to FETCH.
  - MEMWR(5): mem_req=1, IorD=1, MemWrite=1. Waits for mem_ready. instr_done=mem_ready. Goes to FETCH.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUControl from funct. An undefined funct pulses illegal_instr and goes to FETCH; otherwise goes to ALUWB.
  - ALUWB(7): RegDst=01, MemtoReg=00, RegWrite=1, instr_done. Goes to FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01. Branch=1 for beq, BranchNE=1 for bne. instr_done. Goes to FETCH.
  - IEXEC(9): ALUSrcA=1, ALUSrcB=10. ALU op is add, and, or for addi, andi, ori respectively. ImmZext=1 for andi/ori. Goes to IWB.
  - IWB(10): RegDst=00, MemtoReg=00, RegWrite=1, instr_done. Goes to FETCH.
  - JUMP(11): PCSrc=10, PCWrite=1, instr_done. Goes to FETCH.
  - JAL(12): PCSrc=10, PCWrite=1, RegWrite=1, RegDst=10 (r31), MemtoReg=10 (PC, already PC+4), instr_done. Goes to FETCH.
  - HALT(15): all enables 0. Exits only on reset.
- Latencies with zero wait:
  - lw 5 cycles; sw 4; R 4; addi/andi/ori 4; beq/bne 3; j/jal 3.
  - Each wait cycle adds 1.
- Handshake rules:
  - mem_req stays high and all addressing selects stay stable until the mem_ready cycle.
  - mem_ready is ignored in states that do not assert mem_req.
- Timeout:
  - The wait counter increments each cycle in which mem_req=1 and mem_ready=0, and clears on mem_ready or on a state change.
  - If MAX_WAIT≠0 and the counter reaches MAX_WAIT while mem_ready=0: mem_err←1 and next state HALT.
  - No write enable asserts on the timeout cycle.
  - mem_ready on the same cycle the counter reaches MAX_WAIT wins, and the access completes normally.
- Opcode and Funct are sampled only in DECODE and EXEC/IEXEC/BRANCH. The IR is stable after FETCH.
- An asynchronous reset mid-instruction aborts immediately. No partial write enable persists after rst falls.

Test Plan:
- Reset, then R add (Opcode 000000, Funct 100000) with mem_ready=1 → states 0,1,6,7,0; ALUControl=010 in EXEC; RegWrite=1, RegDst=01 in ALUWB; instr_done pulses once.
- lw with mem_ready held low for 3 cycles in MEMRD → mem_req=1, IorD=1 held for 4 cycles; MEMWB follows with MemtoReg=01, RegWrite=1; total 8 cycles.
- MAX_WAIT=8, mem_ready stuck 0 in FETCH → after 8 wait cycles mem_err=1, state=15, IRWrite/PCWrite never asserted; rst low→high returns to state 0 with mem_err=0.
- bne then beq → BranchNE=1, Branch=0, ALUControl=110, PCSrc=01 in state 8 for bne; flags swapped for beq.
- jal with HAS_JAL=1 → state 12: RegDst=10, MemtoReg=10, PCWrite=1, PCSrc=10. Same opcode with HAS_JAL=0 → illegal_instr pulse in DECODE, then FETCH.
- ori, then Opcode 111111, then R Funct 000001 → ori: ImmZext=1, ALUControl=001. Opcode 111111 and Funct 000001 each give one illegal_instr pulse with no RegWrite.
